// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W in Q1.15, with rounding,
// optional /2 scaling and saturation. The twiddle comes from a ROM with a 1-cycle registered output.

module fft_bf_lane #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] p,
  input  logic                     sub,
  input  logic                     scale,
  output logic signed [DATA_W-1:0] res,
  output logic                     clip
);
  logic signed [DATA_W:0]   s;
  logic signed [DATA_W+1:0] h;

  always_comb begin
    s    = sub ? ({a[DATA_W-1], a} - {p[DATA_W-1], p})
               : ({a[DATA_W-1], a} + {p[DATA_W-1], p});
    h    = {s[DATA_W], s} + (DATA_W+2)'(1);
    clip = 1'b0;
    res  = s[DATA_W-1:0];
    if (scale) begin
      res = h[DATA_W:1];
    end else if (s[DATA_W] != s[DATA_W-1]) begin
      // 17-bit sum fits 16 bits only when its top two bits agree
      clip = 1'b1;
      res  = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
endmodule

module fft_butterfly #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        tw_index,
  input  logic                     scale_en,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic [ADDR_W-1:0]        twiddle_address,
  input  logic signed [DATA_W-1:0] real_twiddle,
  input  logic signed [DATA_W-1:0] imag_twiddle,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] x_re,
  output logic signed [DATA_W-1:0] x_im,
  output logic signed [DATA_W-1:0] y_re,
  output logic signed [DATA_W-1:0] y_im,
  output logic                     sat_flag
);
  localparam int STAGES = 3;
  localparam int PW     = 2*DATA_W;
  localparam logic [PW:0]       RND_HALF = (PW+1)'(1) << (DATA_W-2);
  localparam logic [DATA_W-1:0] MAXV     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV     = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  logic [STAGES:0]         vld_pipe;
  cplx_t                   s0_a, s0_b, s1_a, s2_a, s2_p;
  logic                    s0_scale, s1_scale, s2_scale;
  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]      pr, pi;
  logic [DATA_W:0]         rs_re, rs_im;
  logic [3:0][DATA_W-1:0]  lane_a, lane_p, lane_res;
  logic [3:0]              lane_clip;

  assign twiddle_address = tw_index;
  assign out_valid       = vld_pipe[STAGES];

  // Returns {clip, value}: round-half-up Q2.30 -> Q1.15 then clamp.
  function automatic logic [DATA_W:0] rnd_sat(input logic [PW:0] p);
    logic [PW:0]              t;
    logic [PW-2*DATA_W+2:0]   hi;
    t  = p + RND_HALF;
    hi = t[PW:2*DATA_W-2];
    if (&hi || ~|hi) return {1'b0, t[2*DATA_W-2:DATA_W-1]};
    return {1'b1, t[PW] ? MINV : MAXV};
  endfunction

  always_comb begin
    pr    = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    pi    = (PW+1)'(p_ri) + (PW+1)'(p_ir);
    rs_re = rnd_sat(pr);
    rs_im = rnd_sat(pi);
  end

  // lanes: 0 x_re, 1 x_im, 2 y_re, 3 y_im
  assign lane_a = {s2_a.im, s2_a.re, s2_a.im, s2_a.re};
  assign lane_p = {s2_p.im, s2_p.re, s2_p.im, s2_p.re};

  fft_bf_lane #(.DATA_W(DATA_W)) u_lane [3:0] (
    .a     (lane_a),
    .p     (lane_p),
    .sub   (4'b1100),
    .scale ({4{s2_scale}}),
    .res   (lane_res),
    .clip  (lane_clip)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      x_re     <= '0;
      x_im     <= '0;
      y_re     <= '0;
      y_im     <= '0;
      sat_flag <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (in_valid) begin
        s0_a     <= '{re: a_re, im: a_im};
        s0_b     <= '{re: b_re, im: b_im};
        s0_scale <= scale_en;
      end
      // ROM output is aligned with S0 contents here
      p_rr     <= PW'(s0_b.re) * PW'(real_twiddle);
      p_ii     <= PW'(s0_b.im) * PW'(imag_twiddle);
      p_ri     <= PW'(s0_b.re) * PW'(imag_twiddle);
      p_ir     <= PW'(s0_b.im) * PW'(real_twiddle);
      s1_a     <= s0_a;
      s1_scale <= s0_scale;
      s2_a     <= s1_a;
      s2_scale <= s1_scale;
      s2_p     <= '{re: rs_re[DATA_W-1:0], im: rs_im[DATA_W-1:0]};
      if (vld_pipe[1] && (rs_re[DATA_W] || rs_im[DATA_W])) sat_flag <= 1'b1;
      if (vld_pipe[2]) begin
        x_re <= lane_res[0];
        x_im <= lane_res[1];
        y_re <= lane_res[2];
        y_im <= lane_res[3];
        if (|lane_clip) sat_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly with a registered twiddle ROM model.
`timescale 1ns/1ps
module tb_fft_butterfly;
  logic               clock = 1'b0;
  logic               reset, in_valid, scale_en;
  logic [4:0]         tw_index, twiddle_address;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [15:0] real_twiddle, imag_twiddle;
  logic               out_valid, sat_flag;
  logic signed [15:0] x_re, x_im, y_re, y_im;

  logic signed [15:0] rom_re [32];
  logic signed [15:0] rom_im [32];
  logic signed [15:0] ex [4];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    real_twiddle <= rom_re[twiddle_address];
    imag_twiddle <= rom_im[twiddle_address];
  end

  fft_butterfly dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .tw_index(tw_index),
    .scale_en(scale_en), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .twiddle_address(twiddle_address), .real_twiddle(real_twiddle),
    .imag_twiddle(imag_twiddle), .out_valid(out_valid), .x_re(x_re), .x_im(x_im),
    .y_re(y_re), .y_im(y_im), .sat_flag(sat_flag)
  );

  // Drives one butterfly, waits to the negedge after edge N+3; early = out_valid seen sooner.
  task automatic issue(input logic [4:0] tw, input logic sc, input int ar, input int ai,
                       input int br, input int bi, output logic early);
    @(negedge clock);
    in_valid = 1'b1; tw_index = tw; scale_en = sc;
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    @(negedge clock);
    in_valid = 1'b0;
    early = out_valid;
    repeat (2) begin
      @(negedge clock);
      early |= out_valid;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; scale_en = 1'b0; tw_index = 5'd13;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({out_valid, sat_flag, x_re, x_im, y_re, y_im} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b s=%0b x=(%0d,%0d) y=(%0d,%0d) want all 0",
               out_valid, sat_flag, x_re, x_im, y_re, y_im);
    end
    checks++;
    if (twiddle_address !== 5'd13) begin
      errors++;
      $display("FAIL twiddle_address: got %0d want 13", twiddle_address);
    end
  endtask

  task automatic test_basic();
    logic early;
    rom_re[31] = 16'sd32767; rom_im[31] = 16'sd0;
    issue(5'd31, 1'b0, 1000, 0, 2000, 0, early);
    ex = '{16'sd3000, 16'sd0, -16'sd1000, 16'sd0};
    checks++;
    if (early !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got early=%0b valid=%0b want early=0 valid=1", early, out_valid);
    end
    checks++;
    if ({x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]}) begin
      errors++;
      $display("FAIL basic_result: got x=(%0d,%0d) y=(%0d,%0d) want x=(%0d,%0d) y=(%0d,%0d)",
               x_re, x_im, y_re, y_im, ex[0], ex[1], ex[2], ex[3]);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || {x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]}) begin
      errors++;
      $display("FAIL basic_hold: got valid=%0b x=(%0d,%0d) want valid=0 x=(%0d,%0d)",
               out_valid, x_re, x_im, ex[0], ex[1]);
    end
  endtask

  task automatic test_scale();
    logic early;
    issue(5'd31, 1'b1, 1000, 0, 2000, 0, early);
    ex = '{16'sd1500, 16'sd0, -16'sd500, 16'sd0};
    checks++;
    if (out_valid !== 1'b1 || {x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]}) begin
      errors++;
      $display("FAIL scale_result: got v=%0b x=(%0d,%0d) y=(%0d,%0d) want x=(%0d,%0d) y=(%0d,%0d)",
               out_valid, x_re, x_im, y_re, y_im, ex[0], ex[1], ex[2], ex[3]);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL scale_sat: got %0b want 0", sat_flag);
    end
  endtask

  task automatic test_imag();
    logic early;
    rom_re[31] = 16'sd0; rom_im[31] = -16'sd32768;
    issue(5'd31, 1'b0, 0, 0, 1000, 500, early);
    ex = '{16'sd500, -16'sd1000, -16'sd500, 16'sd1000};
    checks++;
    if (out_valid !== 1'b1 || {x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]}) begin
      errors++;
      $display("FAIL imag_result: got v=%0b x=(%0d,%0d) y=(%0d,%0d) want x=(%0d,%0d) y=(%0d,%0d)",
               out_valid, x_re, x_im, y_re, y_im, ex[0], ex[1], ex[2], ex[3]);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL imag_sat: got %0b want 0", sat_flag);
    end
  endtask

  task automatic test_sat_sum();
    logic early;
    rom_re[31] = 16'sd32767; rom_im[31] = 16'sd0;
    issue(5'd31, 1'b0, 30000, 0, 30000, 0, early);
    ex = '{16'sd32767, 16'sd0, 16'sd1, 16'sd0};
    checks++;
    if ({x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]} || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_sum: got x=(%0d,%0d) y=(%0d,%0d) sat=%0b want x=(%0d,%0d) y=(%0d,%0d) sat=1",
               x_re, x_im, y_re, y_im, sat_flag, ex[0], ex[1], ex[2], ex[3]);
    end
  endtask

  task automatic test_sat_product();
    logic early;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    rom_re[31] = -16'sd32768; rom_im[31] = 16'sd0;
    // saturating operands presented while invalid must not set the flag
    in_valid = 1'b0; tw_index = 5'd31; scale_en = 1'b0;
    a_re = 16'sd30000; a_im = '0; b_re = -16'sd32768; b_im = '0;
    repeat (6) @(negedge clock);
    checks++;
    if (sat_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_no_sat: got sat=%0b valid=%0b want 0 0", sat_flag, out_valid);
    end
    issue(5'd31, 1'b0, 0, 0, -32768, 0, early);
    ex = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0};
    checks++;
    if ({x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]} || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_product: got x=(%0d,%0d) y=(%0d,%0d) sat=%0b want x=(%0d,%0d) y=(%0d,%0d) sat=1",
               x_re, x_im, y_re, y_im, sat_flag, ex[0], ex[1], ex[2], ex[3]);
    end
  endtask

  task automatic test_back_to_back();
    // B = 0.5 so P = (floor((wr+1)/2), floor((wi+1)/2)) for each twiddle
    int pre [8] = '{16384, 16069, 15137, 13623, 11585, 9103, 6270, 3197};
    int pim [8] = '{0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};
    logic signed [15:0] got [8][4];
    int got_n = 0, first = -1, last = -1, sx, sy;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clock);
      if (out_valid) begin
        if (got_n < 8) got[got_n] = '{x_re, x_im, y_re, y_im};
        got_n++;
        last = cyc;
        if (first < 0) first = cyc;
      end
      in_valid = (cyc < 8);
      tw_index = 5'(cyc);
      scale_en = cyc[0];
      a_re = 16'(100*cyc); a_im = 16'(-50*cyc); b_re = 16'sd16384; b_im = '0;
    end
    checks++;
    if (got_n != 8 || first != 4 || last != 11) begin
      errors++;
      $display("FAIL b2b_stream: got count=%0d first=%0d last=%0d want 8 4 11", got_n, first, last);
    end
    for (int k = 0; k < 8 && k < got_n; k++) begin
      for (int c = 0; c < 4; c++) begin
        sx = (c[0] ? -50*k : 100*k);
        sy = (c[0] ? pim[k] : pre[k]);
        sx = (c < 2) ? sx + sy : sx - sy;
        if (k % 2 == 1) sx = (sx + 1) >>> 1;
        ex[c] = 16'(sx);
      end
      checks++;
      if ({got[k][0], got[k][1], got[k][2], got[k][3]} !== {ex[0], ex[1], ex[2], ex[3]}) begin
        errors++;
        $display("FAIL b2b_item%0d: got x=(%0d,%0d) y=(%0d,%0d) want x=(%0d,%0d) y=(%0d,%0d)",
                 k, got[k][0], got[k][1], got[k][2], got[k][3], ex[0], ex[1], ex[2], ex[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    int seen = 0;
    @(negedge clock);
    in_valid = 1'b1; tw_index = 5'd31; scale_en = 1'b0;
    a_re = 16'sd30000; a_im = '0; b_re = 16'sd30000; b_im = '0;
    rom_re[31] = 16'sd32767; rom_im[31] = 16'sd0;
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || {sat_flag, x_re, x_im, y_re, y_im} !== 65'd0) begin
      errors++;
      $display("FAIL reset_flush: got valids=%0d sat=%0b x=(%0d,%0d) y=(%0d,%0d) want 0 and zeros",
               seen, sat_flag, x_re, x_im, y_re, y_im);
    end
    issue(5'd31, 1'b0, 1000, 0, 2000, 0, early);
    ex = '{16'sd3000, 16'sd0, -16'sd1000, 16'sd0};
    checks++;
    if (early !== 1'b0 || out_valid !== 1'b1 ||
        {x_re, x_im, y_re, y_im} !== {ex[0], ex[1], ex[2], ex[3]}) begin
      errors++;
      $display("FAIL reset_resume: got v=%0b early=%0b x=(%0d,%0d) y=(%0d,%0d) want x=(%0d,%0d) y=(%0d,%0d)",
               out_valid, early, x_re, x_im, y_re, y_im, ex[0], ex[1], ex[2], ex[3]);
    end
  endtask

  initial begin
    rom_re = '{default: 16'sd0};
    rom_im = '{default: 16'sd0};
    rom_re[0] = 16'sd32767; rom_im[0] = 16'sd0;
    rom_re[1] = 16'sd32138; rom_im[1] = -16'sd6393;
    rom_re[2] = 16'sd30274; rom_im[2] = -16'sd12540;
    rom_re[3] = 16'sd27246; rom_im[3] = -16'sd18205;
    rom_re[4] = 16'sd23170; rom_im[4] = -16'sd23170;
    rom_re[5] = 16'sd18205; rom_im[5] = -16'sd27246;
    rom_re[6] = 16'sd12540; rom_im[6] = -16'sd30274;
    rom_re[7] = 16'sd6393;  rom_im[7] = -16'sd32138;
    test_reset();
    test_basic();
    test_scale();
    test_imag();
    test_sat_sum();
    test_sat_product();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
